// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Common data bus arbiter for the out-of-order core. Completed results from
//   the ALU and the load/store buffer are each queued in a DEPTH-entry FIFO.
//   One FIFO head per cycle is granted, round-robin when both are non-empty,
//   and broadcast through registered cdb_* outputs to the ROB, RS and LSB.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   rdy               global enable; low freezes every register
//   rollback          misprediction flush (empties both FIFOs, clears CDB)
//   alu_flag/...      ALU result push {rob_id, val, rel_pc}
//   alu_stall         ALU FIFO full
//   lsb_flag/...      LSB result push {rob_id, val}; rel_pc stored as 0
//   lsb_stall         LSB FIFO full
//   cdb_flag/...      registered broadcast of the granted entry
//
// Handshake: a source may present src_flag only while src_stall is low. A
//   push while full is dropped. src_stall comes from the registered count
//   only, so a same-cycle pop never frees a slot for a same-cycle push.
//
// DEPTH must be a power of two and at least 2 (pointers wrap modulo DEPTH).
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        alu_flag,
  input  logic [31:0] alu_rob_id,
  input  logic [31:0] alu_val,
  input  logic [31:0] alu_rel_pc,
  output logic        alu_stall,
  input  logic        lsb_flag,
  input  logic [31:0] lsb_rob_id,
  input  logic [31:0] lsb_val,
  output logic        lsb_stall,
  output logic        cdb_flag,
  output logic [31:0] cdb_rob_id,
  output logic [31:0] cdb_val,
  output logic [31:0] cdb_rel_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // last_grant encoding: 0 = ALU, 1 = LSB
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  typedef struct packed {
    logic [31:0] rob_id;
    logic [31:0] val;
    logic [31:0] rel_pc;
  } entry_t;

  entry_t          alu_mem_q [DEPTH];
  entry_t          alu_mem_d [DEPTH];
  entry_t          lsb_mem_q [DEPTH];
  entry_t          lsb_mem_d [DEPTH];
  logic [AW-1:0]   alu_wr_q, alu_wr_d, alu_rd_q, alu_rd_d;
  logic [AW-1:0]   lsb_wr_q, lsb_wr_d, lsb_rd_q, lsb_rd_d;
  logic [CW-1:0]   alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
  logic            last_grant_q, last_grant_d;
  logic            cdb_flag_q, cdb_flag_d;
  entry_t          cdb_ent_q, cdb_ent_d;

  logic alu_full, lsb_full, alu_ne, lsb_ne;
  logic grant_alu, grant_lsb, alu_push, lsb_push;

  always_comb begin
    alu_full  = (alu_cnt_q == FULL_CNT);
    lsb_full  = (lsb_cnt_q == FULL_CNT);
    alu_ne    = (alu_cnt_q != '0);
    lsb_ne    = (lsb_cnt_q != '0);
    // ALU wins unless the LSB also has data and the ALU was granted last.
    grant_alu = alu_ne && (!lsb_ne || (last_grant_q == SRC_LSB));
    grant_lsb = lsb_ne && !grant_alu;
    alu_push  = alu_flag && !alu_full;
    lsb_push  = lsb_flag && !lsb_full;

    alu_mem_d    = alu_mem_q;
    lsb_mem_d    = lsb_mem_q;
    alu_wr_d     = alu_wr_q;
    alu_rd_d     = alu_rd_q;
    lsb_wr_d     = lsb_wr_q;
    lsb_rd_d     = lsb_rd_q;
    alu_cnt_d    = alu_cnt_q;
    lsb_cnt_d    = lsb_cnt_q;
    last_grant_d = last_grant_q;
    cdb_flag_d   = cdb_flag_q;
    cdb_ent_d    = cdb_ent_q;

    if (rdy) begin
      if (rollback) begin
        // Flush wins over push and pop; arbitration history is kept.
        alu_wr_d   = '0;
        alu_rd_d   = '0;
        lsb_wr_d   = '0;
        lsb_rd_d   = '0;
        alu_cnt_d  = '0;
        lsb_cnt_d  = '0;
        cdb_flag_d = 1'b0;
        cdb_ent_d  = '0;
      end else begin
        if (alu_push) begin
          alu_mem_d[alu_wr_q] = '{rob_id: alu_rob_id, val: alu_val, rel_pc: alu_rel_pc};
          alu_wr_d            = alu_wr_q + AW'(1);
        end
        if (lsb_push) begin
          lsb_mem_d[lsb_wr_q] = '{rob_id: lsb_rob_id, val: lsb_val, rel_pc: 32'd0};
          lsb_wr_d            = lsb_wr_q + AW'(1);
        end
        if (grant_alu) alu_rd_d = alu_rd_q + AW'(1);
        if (grant_lsb) lsb_rd_d = lsb_rd_q + AW'(1);
        alu_cnt_d = alu_cnt_q + CW'(alu_push) - CW'(grant_alu);
        lsb_cnt_d = lsb_cnt_q + CW'(lsb_push) - CW'(grant_lsb);

        cdb_flag_d = grant_alu || grant_lsb;
        if (grant_alu) begin
          cdb_ent_d    = alu_mem_q[alu_rd_q];
          last_grant_d = SRC_ALU;
        end else if (grant_lsb) begin
          cdb_ent_d    = lsb_mem_q[lsb_rd_q];
          last_grant_d = SRC_LSB;
        end else begin
          cdb_ent_d    = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        alu_mem_q[i] <= '0;
        lsb_mem_q[i] <= '0;
      end
      alu_wr_q     <= '0;
      alu_rd_q     <= '0;
      lsb_wr_q     <= '0;
      lsb_rd_q     <= '0;
      alu_cnt_q    <= '0;
      lsb_cnt_q    <= '0;
      last_grant_q <= SRC_LSB;  // ALU wins the first contention
      cdb_flag_q   <= 1'b0;
      cdb_ent_q    <= '0;
    end else begin
      alu_mem_q    <= alu_mem_d;
      lsb_mem_q    <= lsb_mem_d;
      alu_wr_q     <= alu_wr_d;
      alu_rd_q     <= alu_rd_d;
      lsb_wr_q     <= lsb_wr_d;
      lsb_rd_q     <= lsb_rd_d;
      alu_cnt_q    <= alu_cnt_d;
      lsb_cnt_q    <= lsb_cnt_d;
      last_grant_q <= last_grant_d;
      cdb_flag_q   <= cdb_flag_d;
      cdb_ent_q    <= cdb_ent_d;
    end
  end

  assign alu_stall  = alu_full;
  assign lsb_stall  = lsb_full;
  assign cdb_flag   = cdb_flag_q;
  assign cdb_rob_id = cdb_ent_q.rob_id;
  assign cdb_val    = cdb_ent_q.val;
  assign cdb_rel_pc = cdb_ent_q.rel_pc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Directed bench for cdb_arbiter (DEPTH=2): a cycle-by-cycle vector table
//   with hand-computed outputs, then hand-written sequences for sustained
//   contention and asynchronous reset in the middle of a burst.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  logic        clk, rst, rdy, rollback;
  logic        alu_flag, lsb_flag, alu_stall, lsb_stall, cdb_flag;
  logic [31:0] alu_rob_id, alu_val, alu_rel_pc;
  logic [31:0] lsb_rob_id, lsb_val;
  logic [31:0] cdb_rob_id, cdb_val, cdb_rel_pc;

  int n_cmp = 0;
  int n_err = 0;

  cdb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .alu_flag(alu_flag), .alu_rob_id(alu_rob_id), .alu_val(alu_val),
    .alu_rel_pc(alu_rel_pc), .alu_stall(alu_stall),
    .lsb_flag(lsb_flag), .lsb_rob_id(lsb_rob_id), .lsb_val(lsb_val),
    .lsb_stall(lsb_stall),
    .cdb_flag(cdb_flag), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
    .cdb_rel_pc(cdb_rel_pc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        rdy, rb;
    logic        af;
    logic [31:0] ar, av, ap;
    logic        lf;
    logic [31:0] lr, lv;
    logic        ef;
    logic [31:0] er, ev, ep;
    logic        eas, els;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rdy_i, input logic rb_i,
                              input logic af_i, input logic [31:0] ar_i,
                              input logic [31:0] av_i, input logic [31:0] ap_i,
                              input logic lf_i, input logic [31:0] lr_i,
                              input logic [31:0] lv_i,
                              input logic ef_i, input logic [31:0] er_i,
                              input logic [31:0] ev_i, input logic [31:0] ep_i,
                              input logic eas_i, input logic els_i);
    vec_t v;
    v.rdy = rdy_i; v.rb = rb_i;
    v.af = af_i; v.ar = ar_i; v.av = av_i; v.ap = ap_i;
    v.lf = lf_i; v.lr = lr_i; v.lv = lv_i;
    v.ef = ef_i; v.er = er_i; v.ev = ev_i; v.ep = ep_i;
    v.eas = eas_i; v.els = els_i;
    return v;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_cdb(input string tag, input logic ef, input logic [31:0] er,
                         input logic [31:0] ev, input logic [31:0] ep);
    chk({tag, ".cdb_flag"},   {31'd0, cdb_flag}, {31'd0, ef});
    chk({tag, ".cdb_rob_id"}, cdb_rob_id, er);
    chk({tag, ".cdb_val"},    cdb_val, ev);
    chk({tag, ".cdb_rel_pc"}, cdb_rel_pc, ep);
  endtask

  task automatic chk_stall(input string tag, input logic eas, input logic els);
    chk({tag, ".alu_stall"}, {31'd0, alu_stall}, {31'd0, eas});
    chk({tag, ".lsb_stall"}, {31'd0, lsb_stall}, {31'd0, els});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    rdy = 1'b1; rollback = 1'b0;
    alu_flag = 1'b0; alu_rob_id = '0; alu_val = '0; alu_rel_pc = '0;
    lsb_flag = 1'b0; lsb_rob_id = '0; lsb_val = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    rdy = v.rdy; rollback = v.rb;
    alu_flag = v.af; alu_rob_id = v.ar; alu_val = v.av; alu_rel_pc = v.ap;
    lsb_flag = v.lf; lsb_rob_id = v.lr; lsb_val = v.lv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected contents for the contention sequence, keyed by rob_id.
  function automatic logic [31:0] exp_val(input logic [31:0] id);
    return (id < 200) ? id * 3 : id * 5;
  endfunction
  function automatic logic [31:0] exp_pc(input logic [31:0] id);
    return (id < 200) ? 32'h3000 + id : 32'd0;
  endfunction

  logic [31:0] exp_q[$];

  // ---------------- main test ----------------
  initial begin
    drive_idle();
    rst = 1'b1;
    #3;
    chk_cdb("reset", 1'b0, 0, 0, 0);
    chk_stall("reset", 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    //            rdy rb af ar  av      ap       lf lr  lv      ef er  ev      ep       eas els
    vecs.push_back(mk(1, 0, 1, 3,  'h10,  0,       0, 0,  0,      0, 0,  0,      0,       0, 0)); // 0 single push
    vecs.push_back(mk(1, 0, 0, 0,  0,     0,       0, 0,  0,      1, 3,  'h10,   0,       0, 0)); // 1 broadcast t+1
    vecs.push_back(mk(1, 0, 0, 0,  0,     0,       0, 0,  0,      0, 0,  0,      0,       0, 0)); // 2 flag drops, zeroed
    vecs.push_back(mk(1, 0, 1, 4,  'h104, 'h1004,  1, 9,  'h209,  0, 0,  0,      0,       0, 0)); // 3 both push
    vecs.push_back(mk(1, 0, 0, 0,  0,     0,       0, 0,  0,      1, 9,  'h209,  0,       0, 0)); // 4 LSB (ALU was last)
    vecs.push_back(mk(1, 0, 0, 0,  0,     0,       0, 0,  0,      1, 4,  'h104,  'h1004,  0, 0)); // 5 ALU with rel_pc
    vecs.push_back(mk(1, 0, 0, 0,  0,     0,       0, 0,  0,      0, 0,  0,      0,       0, 0)); // 6
    vecs.push_back(mk(1, 0, 1, 11, 'h10b, 'h100b,  1, 21, 'h215,  0, 0,  0,      0,       0, 0)); // 7
    vecs.push_back(mk(1, 0, 1, 12, 'h10c, 'h100c,  1, 22, 'h216,  1, 21, 'h215,  0,       1, 0)); // 8 ALU fills
    vecs.push_back(mk(1, 0, 1, 13, 'h10d, 'h100d,  1, 23, 'h217,  1, 11, 'h10b,  'h100b,  0, 1)); // 9 push while full dropped
    vecs.push_back(mk(1, 0, 0, 0,  0,     0,       0, 0,  0,      1, 22, 'h216,  0,       0, 0)); // 10
    vecs.push_back(mk(0, 0, 1, 14, 'h10e, 'h100e,  0, 0,  0,      1, 22, 'h216,  0,       0, 0)); // 11 rdy=0 hold
    vecs.push_back(mk(0, 1, 0, 0,  0,     0,       0, 0,  0,      1, 22, 'h216,  0,       0, 0)); // 12 rollback ignored
    vecs.push_back(mk(0, 0, 0, 0,  0,     0,       0, 0,  0,      1, 22, 'h216,  0,       0, 0)); // 13
    vecs.push_back(mk(1, 0, 0, 0,  0,     0,       0, 0,  0,      1, 12, 'h10c,  'h100c,  0, 0)); // 14 resume
    vecs.push_back(mk(1, 0, 0, 0,  0,     0,       0, 0,  0,      1, 23, 'h217,  0,       0, 0)); // 15
    vecs.push_back(mk(1, 0, 1, 31, 'h11f, 'h101f,  1, 41, 'h229,  0, 0,  0,      0,       0, 0)); // 16
    vecs.push_back(mk(1, 0, 1, 32, 'h120, 'h1020,  1, 42, 'h22a,  1, 31, 'h11f,  'h101f,  0, 1)); // 17
    vecs.push_back(mk(1, 1, 1, 33, 'h121, 'h1021,  0, 0,  0,      0, 0,  0,      0,       0, 0)); // 18 rollback + push
    vecs.push_back(mk(1, 0, 0, 0,  0,     0,       0, 0,  0,      0, 0,  0,      0,       0, 0)); // 19 nothing survives
    vecs.push_back(mk(1, 0, 1, 34, 'h122, 'h1022,  1, 43, 'h22b,  0, 0,  0,      0,       0, 0)); // 20
    vecs.push_back(mk(1, 0, 0, 0,  0,     0,       0, 0,  0,      1, 43, 'h22b,  0,       0, 0)); // 21 last_grant kept (ALU)
    vecs.push_back(mk(1, 0, 0, 0,  0,     0,       0, 0,  0,      1, 34, 'h122,  'h1022,  0, 0)); // 22
    vecs.push_back(mk(1, 0, 0, 0,  0,     0,       0, 0,  0,      0, 0,  0,      0,       0, 0)); // 23

    for (int i = 0; i < vecs.size(); i++) begin
      drive_vec(vecs[i]);
      tick();
      chk_cdb($sformatf("vec%0d", i), vecs[i].ef, vecs[i].er, vecs[i].ev, vecs[i].ep);
      chk_stall($sformatf("vec%0d", i), vecs[i].eas, vecs[i].els);
    end
    drive_idle();

    // ---- sustained contention from reset: strict ALU/LSB alternation ----
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'd100 + 32'(i));
      exp_q.push_back(32'd200 + 32'(i));
    end
    begin
      int ai = 0;
      int li = 0;
      int cyc = 0;
      int seen = 0;
      logic saw_stall = 1'b0;
      while (exp_q.size() > 0 && cyc < 60) begin
        alu_flag   = (ai < 8) && !alu_stall;
        alu_rob_id = 32'd100 + 32'(ai);
        alu_val    = exp_val(alu_rob_id);
        alu_rel_pc = exp_pc(alu_rob_id);
        lsb_flag   = (li < 8) && !lsb_stall;
        lsb_rob_id = 32'd200 + 32'(li);
        lsb_val    = exp_val(lsb_rob_id);
        tick();
        cyc++;
        if (alu_flag) ai++;
        if (lsb_flag) li++;
        if (alu_stall || lsb_stall) saw_stall = 1'b1;
        if (cdb_flag) begin
          logic [31:0] e;
          e = exp_q.pop_front();
          seen++;
          chk($sformatf("burst%0d.rob_id", seen), cdb_rob_id, e);
          chk($sformatf("burst%0d.val", seen), cdb_val, exp_val(e));
          chk($sformatf("burst%0d.rel_pc", seen), cdb_rel_pc, exp_pc(e));
        end
      end
      drive_idle();
      chk("burst.remaining", 32'(exp_q.size()), 32'd0);
      chk("burst.broadcasts", 32'(seen), 32'd16);
      chk("burst.saw_stall", {31'd0, saw_stall}, 32'd1);
      tick();
      chk_cdb("burst.after", 1'b0, 0, 0, 0);
    end

    // ---- asynchronous reset in the middle of a burst ----
    alu_flag = 1'b1; alu_rob_id = 32'd70; alu_val = 32'h70; alu_rel_pc = 32'h7000;
    lsb_flag = 1'b1; lsb_rob_id = 32'd80; lsb_val = 32'h80;
    tick();
    alu_rob_id = 32'd71; alu_val = 32'h71; alu_rel_pc = 32'h7001;
    lsb_rob_id = 32'd81; lsb_val = 32'h81;
    tick();
    // last grant was the LSB, so ALU 70 goes first; LSB now holds 80,81.
    chk_cdb("preburst", 1'b1, 70, 'h70, 'h7000);
    chk_stall("preburst", 1'b0, 1'b1);
    drive_idle();
    #2;
    rst = 1'b1;
    #1;
    chk_cdb("async_rst", 1'b0, 0, 0, 0);
    chk_stall("async_rst", 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    tick();
    chk_cdb("post_rst_empty", 1'b0, 0, 0, 0);
    alu_flag = 1'b1; alu_rob_id = 32'd50; alu_val = 32'h50; alu_rel_pc = 32'h5000;
    lsb_flag = 1'b1; lsb_rob_id = 32'd60; lsb_val = 32'h60;
    tick();
    drive_idle();
    chk_cdb("post_rst_push", 1'b0, 0, 0, 0);
    tick();
    chk_cdb("post_rst_alu", 1'b1, 50, 'h50, 'h5000);
    tick();
    chk_cdb("post_rst_lsb", 1'b1, 60, 'h60, 0);
    tick();
    chk_cdb("post_rst_idle", 1'b0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
